sdspi_sweep_sequencer: RTL and testbench

Test sequencer placed directly upstream of the SD-SPI read-test system. It drives that system's `start`, `n_blocks`, `cmd18` and `sclk_speed` inputs and resets it between runs. It sweeps every SCLK speed in a configured range in both read modes (single-block, then CMD18 multi-block), timing each run from `start` to `finish`. Each cycle count goes into a 64-entry result memory, which a host or debug reader reads back after `done`.

---
 rtl/sdspi_sweep_sequencer.sv | 141 ++++++++++++++
 tb/tb_sdspi_sweep_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdspi_sweep_sequencer.sv
// Sweep sequencer for the SD-SPI read-test system: times each run over a speed range in both read modes.
// Optional per-run timeout is compiled in with `define SDSPI_SEQ_TIMEOUT_EN.
module sdspi_sweep_sequencer #(
  parameter int unsigned RST_CYCLES     = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h0FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [31:0] n_blocks_cfg,
  input  logic [4:0]  speed_min,
  input  logic [4:0]  speed_max,
  output logic        busy,
  output logic        done,
  output logic        timeout_seen,
  output logic        dut_rst,
  output logic        dut_start,
  input  logic        dut_finish,
  output logic [31:0] dut_n_blocks,
  output logic        dut_cmd18,
  output logic [4:0]  dut_sclk_speed,
  input  logic [5:0]  rd_addr,
  output logic [31:0] rd_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_DUT, S_LAUNCH, S_RUN, S_STORE, S_NEXT, S_DONE
  } state_t;

  state_t      state, state_next;
  logic [31:0] rst_cnt;
  logic [31:0] run_cnt;
  logic [31:0] n_blocks;
  logic [4:0]  speed;
  logic [4:0]  eff_max;
  logic        mode;
  logic        timeout_flag;
  logic        run_timeout;
  logic [31:0] mem [64];

`ifdef SDSPI_SEQ_TIMEOUT_EN
  assign run_timeout = (run_cnt == TIMEOUT_CYCLES) && !dut_finish;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign run_timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Host handshake: go is a level request accepted in IDLE; done stays high
  // until the host drops go, so a held go never starts a second sweep.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (go) state_next = S_RST_DUT;
      S_RST_DUT: if (rst_cnt == RST_CYCLES - 1) state_next = S_LAUNCH;
      S_LAUNCH:  state_next = S_RUN;
      S_RUN:     if (dut_finish || run_timeout) state_next = S_STORE;
      S_STORE:   state_next = S_NEXT;
      S_NEXT: begin
        if (!mode)                 state_next = S_RST_DUT;
        else if (speed >= eff_max) state_next = S_DONE;
        else                       state_next = S_RST_DUT;
      end
      S_DONE:    if (!go) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt      <= '0;
      run_cnt      <= '0;
      n_blocks     <= '0;
      speed        <= '0;
      eff_max      <= '0;
      mode         <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            n_blocks     <= n_blocks_cfg;
            speed        <= speed_min;
            eff_max      <= (speed_max >= speed_min) ? speed_max : speed_min;
            mode         <= 1'b0;
            timeout_flag <= 1'b0;
            rst_cnt      <= '0;
          end
        end
        S_RST_DUT: rst_cnt <= rst_cnt + 32'd1;
        S_LAUNCH:  run_cnt <= 32'd1;
        S_RUN: begin
          if (!dut_finish) begin
            // A timed-out run leaves the all-ones marker as its result.
            if (run_timeout) begin
              run_cnt      <= 32'hFFFF_FFFF;
              timeout_flag <= 1'b1;
            end else begin
              run_cnt <= run_cnt + 32'd1;
            end
          end
        end
        S_NEXT: begin
          rst_cnt <= '0;
          if (!mode) begin
            mode <= 1'b1;
          end else if (speed < eff_max) begin
            speed <= speed + 5'd1;
            mode  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Result memory has no reset; a reset during STORE drops the write.
  always_ff @(posedge clk) begin
    if (!rst && state == S_STORE) mem[{speed, mode}] <= run_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

  assign busy           = (state != S_IDLE) && (state != S_DONE);
  assign done           = (state == S_DONE);
  assign dut_rst        = (state == S_IDLE) || (state == S_RST_DUT);
  assign dut_start      = (state == S_LAUNCH);
  assign dut_n_blocks   = n_blocks;
  assign dut_cmd18      = mode;
  assign dut_sclk_speed = speed;
  assign timeout_seen   = timeout_flag;

endmodule

// File: tb/tb_sdspi_sweep_sequencer.sv
// Randomized bench for sdspi_sweep_sequencer with a behavioural read-test-system model and scoreboard.
// Timeout scenarios are included when SDSPI_SEQ_TIMEOUT_EN is defined.
module tb_sdspi_sweep_sequencer;

  localparam int unsigned RST_CYCLES = 2;
  localparam int unsigned TO_CYCLES  = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [31:0] n_blocks_cfg = '0;
  logic [4:0]  speed_min = '0;
  logic [4:0]  speed_max = '0;
  logic        busy, done, timeout_seen, dut_rst, dut_start, dut_cmd18;
  logic        dut_finish = 1'b0;
  logic [31:0] dut_n_blocks;
  logic [4:0]  dut_sclk_speed;
  logic [5:0]  rd_addr = '0;
  logic [31:0] rd_data;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [5:0]  exp_q[$];
  logic [31:0] shadow [64];
  bit          shadow_vld [64];
  int unsigned lat_tab [64];
  logic [31:0] cur_n_blocks = '0;
  bit          first_run = 1'b1;
  int          n_starts = 0;

  // model state of the read-test system
  bit          armed = 1'b0;
  int unsigned el = 0;
  int unsigned lat = 0;
  int          rst_len = 0;
  logic [31:0] exp_run;

  sdspi_sweep_sequencer #(
    .RST_CYCLES    (RST_CYCLES),
    .TIMEOUT_CYCLES(32'(TO_CYCLES))
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .go            (go),
    .n_blocks_cfg  (n_blocks_cfg),
    .speed_min     (speed_min),
    .speed_max     (speed_max),
    .busy          (busy),
    .done          (done),
    .timeout_seen  (timeout_seen),
    .dut_rst       (dut_rst),
    .dut_start     (dut_start),
    .dut_finish    (dut_finish),
    .dut_n_blocks  (dut_n_blocks),
    .dut_cmd18     (dut_cmd18),
    .dut_sclk_speed(dut_sclk_speed),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_value(input int unsigned l);
`ifdef SDSPI_SEQ_TIMEOUT_EN
    if (l > TO_CYCLES) return 32'hFFFF_FFFF;
`endif
    return 32'(l);
  endfunction

  function automatic int unsigned run_len(input int unsigned l);
`ifdef SDSPI_SEQ_TIMEOUT_EN
    if (l > TO_CYCLES) return TO_CYCLES;
`endif
    return l;
  endfunction

  // Read-test system model: finish rises L cycles after the start cycle, cleared by dut_rst.
  always @(posedge clk) begin
    if (dut_rst) begin
      armed = 1'b0;
      el    = 0;
      rst_len++;
    end else begin
      if (dut_start) begin
        if (exp_q.size() > 0) exp_run = 32'(exp_q.pop_front());
        else                  exp_run = 32'hDEAD_BEEF;
        check("run_order", {26'd0, dut_sclk_speed, dut_cmd18}, exp_run);
        check("run_n_blocks", dut_n_blocks, cur_n_blocks);
        if (!first_run) check("rst_len", 32'(rst_len), 32'(RST_CYCLES));
        first_run = 1'b0;
        n_starts++;
        armed = 1'b1;
        el    = 1;
        lat   = lat_tab[{dut_sclk_speed, dut_cmd18}];
      end else if (armed) begin
        el++;
      end
      rst_len = 0;
    end
    #1 dut_finish = armed && (el >= lat);
  end

  task automatic start_sweep(input logic [4:0] smin, input logic [4:0] smax, input logic [31:0] nb,
                             output int total, output bit any_to);
    int eff;
    logic [5:0] idx;
    eff    = (smax >= smin) ? int'(smax) : int'(smin);
    total  = 0;
    any_to = 1'b0;
    exp_q.delete();
    for (int s = int'(smin); s <= eff; s++) begin
      for (int m = 0; m < 2; m++) begin
        idx = {s[4:0], m[0]};
        exp_q.push_back(idx);
        total += int'(RST_CYCLES) + 3 + int'(run_len(lat_tab[idx]));
        if (model_value(lat_tab[idx]) == 32'hFFFF_FFFF) any_to = 1'b1;
      end
    end
    @(negedge clk);
    n_blocks_cfg = nb;
    speed_min    = smin;
    speed_max    = smax;
    cur_n_blocks = nb;
    first_run    = 1'b1;
    n_starts     = 0;
    go           = 1'b1;
  endtask

  task automatic run_sweep(input logic [4:0] smin, input logic [4:0] smax, input logic [31:0] nb,
                           input int hold);
    int total, n, eff;
    bit any_to;
    logic [5:0] idx;
    start_sweep(smin, smax, nb, total, any_to);
    n = 0;
    while (!done && n < total + 200) begin
      @(negedge clk);
      n++;
      if (n == 1) check("ts_clear", {31'd0, timeout_seen}, 32'd0);
    end
    check("sweep_cycles", 32'(n), 32'(total + 1));
    check("done", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    check("runs_left", 32'(exp_q.size()), 32'd0);
    check("timeout_seen", {31'd0, timeout_seen}, {31'd0, any_to});
    repeat (hold) begin
      @(negedge clk);
      check("done_hold", {31'd0, done}, 32'd1);
    end
    go = 1'b0;
    @(negedge clk);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_dut_rst", {31'd0, dut_rst}, 32'd1);
    eff = (smax >= smin) ? int'(smax) : int'(smin);
    for (int s = int'(smin); s <= eff; s++) begin
      for (int m = 0; m < 2; m++) begin
        idx = {s[4:0], m[0]};
        shadow[idx]     = model_value(lat_tab[idx]);
        shadow_vld[idx] = 1'b1;
      end
    end
  endtask

  task automatic readback();
    int prev = -1;
    for (int i = 0; i < 64; i++) begin
      if (shadow_vld[i]) begin
        @(negedge clk);
        rd_addr = 6'(i);
        #1;
        if (prev >= 0) check("rd_latency", rd_data, shadow[prev]);
        @(negedge clk);
        check($sformatf("rd_%0d", i), rd_data, shadow[i]);
        prev = i;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_dut_rst"}, {31'd0, dut_rst}, 32'd1);
    check({tag, "_dut_start"}, {31'd0, dut_start}, 32'd0);
    check({tag, "_timeout_seen"}, {31'd0, timeout_seen}, 32'd0);
    check({tag, "_n_blocks"}, dut_n_blocks, 32'd0);
    check({tag, "_cmd18"}, {31'd0, dut_cmd18}, 32'd0);
    check({tag, "_speed"}, {27'd0, dut_sclk_speed}, 32'd0);
    check({tag, "_rd_data"}, rd_data, 32'd0);
  endtask

  task automatic abort_test();
    int total, n;
    bit any_to;
    lat_tab[{5'd3, 1'b0}] = 5;
    lat_tab[{5'd3, 1'b1}] = 30;
    start_sweep(5'd3, 5'd4, $urandom, total, any_to);
    n = 0;
    while (n_starts < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach", 32'(n_starts), 32'd2);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    go  = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("abort");
    @(negedge clk);
    rst = 1'b0;
    shadow[{5'd3, 1'b0}] = 32'd5;
  endtask

  // main sequence
  initial begin
    logic [4:0] smin, smax;
    for (int i = 0; i < 64; i++) begin
      lat_tab[i]    = 10;
      shadow_vld[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    run_sweep(5'd3, 5'd4, 32'd8, 0);
    lat_tab[10] = 100;
    lat_tab[11] = 37;
    run_sweep(5'd5, 5'd5, 32'd0, 1);
    run_sweep(5'd7, 5'd2, 32'd1, 0);
    run_sweep(5'd31, 5'd31, 32'hFFFF_FFFF, 3);
    readback();

    abort_test();
    readback();
    run_sweep(5'd3, 5'd3, 32'd16, 0);

`ifdef SDSPI_SEQ_TIMEOUT_EN
    lat_tab[{5'd9, 1'b1}] = 1000;
    run_sweep(5'd8, 5'd9, 32'd4, 0);
`endif

    for (int k = 0; k < 6; k++) begin
      smin = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) smax = 5'($urandom_range(0, 31));
      else if (smin > 5'd28)         smax = 5'd31;
      else                           smax = smin + 5'($urandom_range(0, 2));
      for (int i = 0; i < 64; i++) lat_tab[i] = $urandom_range(1, 40);
      run_sweep(smin, smax, $urandom, $urandom_range(0, 3));
    end
    readback();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
